// File: rtl/uart_cmd_framer.sv
// Assembles [SYNC][CMD][~CMD] controller frames from a UART byte stream and holds the
// decoded button state for a bounded time, so a dead link releases every button.
module uart_cmd_framer #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned BYTE_TIMEOUT = 216_000,
    parameter int unsigned HOLD_CYCLES  = 10_800_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_right,
    output logic       o_left,
    output logic       o_jump,
    output logic       o_squat,
    output logic       o_attack,
    output logic       o_defend,
    output logic       o_select,
    output logic       o_jump_pulse,
    output logic       o_attack_pulse,
    output logic       o_select_pulse,
    output logic       o_frame_ok,
    output logic [7:0] o_err_cnt,
    output logic       o_link
);

    localparam int TO_W   = $clog2(BYTE_TIMEOUT + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(BYTE_TIMEOUT - 1);
    localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_CHK  = 2'd2;

    // Opposing directions pressed together cancel each other out.
    function automatic logic [6:0] resolve_dirs(input logic [6:0] cmd);
        if (cmd[1:0] == 2'b11) begin
            return {cmd[6:2], 2'b00};
        end else begin
            return cmd;
        end
    endfunction

    logic              valid_prev_q;
    logic [1:0]        state_q, state_d;
    logic [6:0]        cmd_q, cmd_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic [6:0]        held_q, held_d;
    logic [6:0]        held_prev_q;
    logic [2:0]        pulse_q, pulse_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              frame_ok_q;
    logic              link_q;

    logic strobe_s;
    logic to_expire_s;
    logic accept_s;
    logic reject_s;

    assign strobe_s    = i_valid & ~valid_prev_q;
    assign to_expire_s = (to_cnt_q == TO_LAST);

    // Frame parser: a pending byte always beats an expiring inter-byte timeout.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        to_cnt_d = to_cnt_q;
        accept_s = 1'b0;
        reject_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                to_cnt_d = '0;
                if (strobe_s && (i_data == SYNC_BYTE)) begin
                    state_d = S_CMD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CMD: begin
                if (strobe_s) begin
                    to_cnt_d = '0;
                    if (!i_data[7]) begin
                        cmd_d   = i_data[6:0];
                        state_d = S_CHK;
                    end else begin
                        reject_s = 1'b1;
                        state_d  = S_IDLE;
                    end
                end else if (to_expire_s) begin
                    reject_s = 1'b1;
                    to_cnt_d = '0;
                    state_d  = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_ONE;
                end
            end
            S_CHK: begin
                if (strobe_s) begin
                    to_cnt_d = '0;
                    state_d  = S_IDLE;
                    if (i_data == ~{1'b0, cmd_q}) begin
                        accept_s = 1'b1;
                    end else begin
                        reject_s = 1'b1;
                    end
                end else if (to_expire_s) begin
                    reject_s = 1'b1;
                    to_cnt_d = '0;
                    state_d  = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_ONE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                to_cnt_d = '0;
            end
        endcase
    end

    // Button hold: a new accept reloads even in the cycle the old hold expires.
    always_comb begin
        held_d     = held_q;
        hold_cnt_d = hold_cnt_q;
        if (accept_s) begin
            held_d     = resolve_dirs(cmd_q);
            hold_cnt_d = HOLD_LOAD;
        end else if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - HOLD_ONE;
            if (hold_cnt_q == HOLD_ONE) begin
                held_d = '0;
            end else begin
                held_d = held_q;
            end
        end else begin
            held_d     = held_q;
            hold_cnt_d = hold_cnt_q;
        end
    end

    // Rejected-frame counter and rising-edge pulses of the one-shot buttons.
    always_comb begin
        if (reject_s && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
        pulse_d = {held_q[6] & ~held_prev_q[6],
                   held_q[4] & ~held_prev_q[4],
                   held_q[2] & ~held_prev_q[2]};
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_prev_q <= 1'b0;
            state_q      <= S_IDLE;
            cmd_q        <= '0;
            to_cnt_q     <= '0;
            err_cnt_q    <= 8'd0;
            held_q       <= '0;
            held_prev_q  <= '0;
            pulse_q      <= 3'b000;
            hold_cnt_q   <= '0;
            frame_ok_q   <= 1'b0;
            link_q       <= 1'b0;
        end else begin
            valid_prev_q <= i_valid;
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            to_cnt_q     <= to_cnt_d;
            err_cnt_q    <= err_cnt_d;
            held_q       <= held_d;
            held_prev_q  <= held_q;
            pulse_q      <= pulse_d;
            hold_cnt_q   <= hold_cnt_d;
            frame_ok_q   <= accept_s;
            link_q       <= (hold_cnt_d != '0);
        end
    end

    assign o_right        = held_q[0];
    assign o_left         = held_q[1];
    assign o_jump         = held_q[2];
    assign o_squat        = held_q[3];
    assign o_attack       = held_q[4];
    assign o_defend       = held_q[5];
    assign o_select       = held_q[6];
    assign o_jump_pulse   = pulse_q[0];
    assign o_attack_pulse = pulse_q[1];
    assign o_select_pulse = pulse_q[2];
    assign o_frame_ok     = frame_ok_q;
    assign o_err_cnt      = err_cnt_q;
    assign o_link         = link_q;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Scoreboard bench: a byte-level frame model predicts accept/error events with their
// cycle; a negedge monitor pops them and also tracks hold expiry and edge pulses.
module tb_uart_cmd_framer;

    localparam int B = 40;
    localparam int H = 50;

    logic       clk = 1'b0;
    logic       i_rst_n;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_right, o_left, o_jump, o_squat, o_attack, o_defend, o_select;
    logic       o_jump_pulse, o_attack_pulse, o_select_pulse, o_frame_ok, o_link;
    logic [7:0] o_err_cnt;

    always #5 clk = ~clk;

    uart_cmd_framer #(
        .SYNC_BYTE   (8'hA5),
        .BYTE_TIMEOUT(B),
        .HOLD_CYCLES (H)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (i_rst_n),
        .i_data        (i_data),
        .i_valid       (i_valid),
        .o_right       (o_right),
        .o_left        (o_left),
        .o_jump        (o_jump),
        .o_squat       (o_squat),
        .o_attack      (o_attack),
        .o_defend      (o_defend),
        .o_select      (o_select),
        .o_jump_pulse  (o_jump_pulse),
        .o_attack_pulse(o_attack_pulse),
        .o_select_pulse(o_select_pulse),
        .o_frame_ok    (o_frame_ok),
        .o_err_cnt     (o_err_cnt),
        .o_link        (o_link)
    );

    typedef struct { int cyc; logic [6:0] bits; } frame_exp_t;
    typedef struct { int cyc; logic [7:0] val;  } err_exp_t;

    frame_exp_t fq[$];
    err_exp_t   eq[$];
    logic [7:0] pend[$];
    int         last_t;
    int         err_model;
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    bit         rst_edge = 1'b0;
    bit         mon_en = 1'b0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= !i_rst_n;
    end

    task automatic chk(input string name, input int act, input int exp, input int at);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, at);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_error(input int at);
        if (err_model < 255) begin
            err_model++;
            eq.push_back('{at, 8'(err_model)});
        end
    endtask

    // A frame in progress dies once more than B cycles pass between byte strobes.
    task automatic model_tick();
        if (pend.size() > 0 && (cyc - last_t) > B) begin
            model_error(last_t + B + 1);
            pend.delete();
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input int c);
        logic [6:0] bits;
        if (pend.size() == 0) begin
            if (b == 8'hA5) begin
                pend.push_back(b);
                last_t = c;
            end
        end else if (pend.size() == 1) begin
            if (b[7]) begin
                model_error(c + 1);
                pend.delete();
            end else begin
                pend.push_back(b);
                last_t = c;
            end
        end else begin
            if (b == ~pend[1]) begin
                bits = pend[1][6:0];
                if (bits[1] && bits[0]) bits[1:0] = 2'b00;
                fq.push_back('{c + 1, bits});
            end else begin
                model_error(c + 1);
            end
            pend.delete();
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        model_tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input int len, input int gap);
        i_data  = b;
        i_valid = 1'b1;
        model_byte(b, cyc);
        repeat (len) step();
        i_valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic send_frame(input logic [7:0] s, input logic [7:0] c, input logic [7:0] k,
                              input int len, input int gap);
        send_byte(s, len, gap);
        send_byte(c, len, gap);
        send_byte(k, len, gap);
    endtask

    task automatic do_reset(input int n);
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        pend.delete();
        fq.delete();
        eq.delete();
        err_model = 0;
        repeat (n) step();
        i_rst_n = 1'b1;
        step();
    endtask

    // ---------------- monitor ----------------
    logic [6:0] exp_held = 7'd0;
    logic [6:0] h1 = 7'd0;
    logic [6:0] h2 = 7'd0;
    int         expiry = 0;
    logic [7:0] last_err = 8'd0;

    always @(negedge clk) begin
        logic [6:0] act_held;
        logic [2:0] exp_pulse;
        frame_exp_t fe;
        err_exp_t   ee;
        if (mon_en) begin
            act_held = {o_select, o_defend, o_attack, o_squat, o_jump, o_left, o_right};
            if (rst_edge) begin
                exp_held = 7'd0;
                h1       = 7'd0;
                h2       = 7'd0;
                expiry   = 0;
                last_err = 8'd0;
                chk("reset_outputs", {o_frame_ok, o_link, o_jump_pulse, o_attack_pulse,
                                      o_select_pulse, act_held, o_err_cnt}, 0, cyc);
            end else begin
                if (o_frame_ok) begin
                    if (fq.size() == 0) begin
                        chk("frame_ok_unexpected", o_frame_ok, 0, cyc);
                    end else begin
                        fe = fq.pop_front();
                        chk("frame_ok_cycle", cyc, fe.cyc, cyc);
                        exp_held = fe.bits;
                        expiry   = fe.cyc + H;
                    end
                end else if (fq.size() > 0 && fq[0].cyc <= cyc) begin
                    fe = fq.pop_front();
                    chk("frame_ok_missing", o_frame_ok, 1, cyc);
                    exp_held = fe.bits;
                    expiry   = fe.cyc + H;
                end
                if (cyc >= expiry) exp_held = 7'd0;
                chk("held_buttons", act_held, exp_held, cyc);
                chk("link", o_link, (cyc < expiry) ? 1 : 0, cyc);
                exp_pulse = {h1[6] & ~h2[6], h1[4] & ~h2[4], h1[2] & ~h2[2]};
                chk("pulses", {o_select_pulse, o_attack_pulse, o_jump_pulse}, exp_pulse, cyc);
                h2 = h1;
                h1 = exp_held;
                if (o_err_cnt != last_err) begin
                    if (eq.size() == 0) begin
                        chk("err_cnt_unexpected", o_err_cnt, last_err, cyc);
                    end else begin
                        ee = eq.pop_front();
                        chk("err_cnt_value", o_err_cnt, ee.val, cyc);
                        chk("err_cnt_cycle", cyc, ee.cyc, cyc);
                    end
                    last_err = o_err_cnt;
                end else if (eq.size() > 0 && eq[0].cyc <= cyc) begin
                    ee = eq.pop_front();
                    chk("err_cnt_missing", o_err_cnt, ee.val, cyc);
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] cmd;
        int         kind;
        i_rst_n   = 1'b0;
        i_valid   = 1'b0;
        i_data    = 8'h00;
        err_model = 0;
        last_t    = 0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        do_reset(2);

        // Basic accept, then let the hold run out.
        send_frame(8'hA5, 8'h05, 8'hFA, 1, 2);
        repeat (3) step();
        chk("t1_right", o_right, 1, cyc);
        chk("t1_jump", o_jump, 1, cyc);
        chk("t1_link", o_link, 1, cyc);
        repeat (H + 5) step();
        chk("t2_link_off", o_link, 0, cyc);

        // Bad check byte, then CMD with bit 7 set.
        send_frame(8'hA5, 8'h05, 8'hFB, 1, 2);
        send_frame(8'hA5, 8'h85, 8'h7A, 1, 2);
        repeat (3) step();
        chk("t3_err_cnt", o_err_cnt, 2, cyc);

        // Timeout after SYNC; trailing bytes are discarded in idle.
        send_byte(8'hA5, 1, 2 * B);
        send_byte(8'h05, 1, 2);
        send_byte(8'hFA, 1, 2);
        repeat (3) step();
        chk("t4_err_cnt", o_err_cnt, 3, cyc);

        // Gap of exactly B cycles survives; B+1 cycles times out.
        send_frame(8'hA5, 8'h11, 8'hEE, 1, B - 1);
        send_byte(8'hA5, 1, B);
        send_byte(8'h11, 1, 2);
        send_byte(8'hEE, 1, 2);
        repeat (3) step();
        chk("t4b_err_cnt", o_err_cnt, 4, cyc);

        // Long valid level per byte, right+left conflict.
        send_frame(8'hA5, 8'h03, 8'hFC, 20, 3);
        repeat (2) step();
        chk("t5_right", o_right, 0, cyc);
        chk("t5_left", o_left, 0, cyc);
        repeat (H + 5) step();

        // Randomised traffic.
        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 6);
            cmd  = 8'($urandom_range(0, 127));
            case (kind)
                0, 1, 2: send_frame(8'hA5, cmd, ~cmd, $urandom_range(1, 3), $urandom_range(1, 8));
                3: send_frame(8'hA5, cmd, ~cmd ^ 8'($urandom_range(1, 255)), 1, $urandom_range(1, 8));
                4: send_frame(8'hA5, cmd | 8'h80, ~cmd, 1, $urandom_range(1, 8));
                5: send_byte(8'($urandom), $urandom_range(1, 3), $urandom_range(1, 8));
                default: begin
                    send_byte(8'hA5, 1, 2);
                    if ($urandom_range(0, 1) == 1) send_byte(cmd, 1, 2);
                    repeat (B + $urandom_range(0, 10)) step();
                end
            endcase
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, H + 10)) step();
        end
        repeat (B + 5) step();
        chk("rand_err_cnt", o_err_cnt, err_model, cyc);

        // Saturation of the error counter.
        for (int i = 0; i < 300; i++) send_frame(8'hA5, 8'h85, 8'h7A, 1, 1);
        repeat (3) step();
        chk("sat_err_cnt", o_err_cnt, 255, cyc);

        // Reset mid-hold and mid-frame; the partial frame is not counted.
        send_frame(8'hA5, 8'h7C, 8'h83, 1, 2);
        repeat (5) step();
        send_byte(8'hA5, 1, 1);
        send_byte(8'h15, 1, 0);
        do_reset(1);
        send_frame(8'hA5, 8'h05, 8'hFA, 1, 2);
        repeat (H + B + 10) step();
        chk("post_reset_err_cnt", o_err_cnt, 0, cyc);
        chk("frame_queue_drained", fq.size(), 0, cyc);
        chk("err_queue_drained", eq.size(), 0, cyc);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
